// File: rtl/pc_target_unit.sv
// Program counter with a runtime-writable branch target table (absolute or PC-relative entries) and sticky fault.
// Latency: one edge, inputs at edge N visible after N; no backpressure, halt holds pc and drops any branch.
module pc_target_unit #(
    parameter int D = 10,
    parameter int A = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         halt,
    input  logic         branch_en,
    input  logic [A-1:0] branch_idx,
    input  logic         tbl_we,
    input  logic [A-1:0] tbl_waddr,
    input  logic [D-1:0] tbl_wdata,
    input  logic         tbl_wrel,
    output logic [D-1:0] pc,
    output logic         taken,
    output logic         fault
);
    localparam int N = 2 ** A;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    localparam logic [D-1:0] PC_ONE = D'(1);

    logic [1:0]   r_state;
    logic [D-1:0] r_pc;
    logic         r_taken;
    logic         r_fault;

    logic [N-1:0] r_vld;
    logic [N-1:0] r_rel;
    logic [D-1:0] r_val [N];

    logic         w_ent_vld;
    logic         w_ent_rel;
    logic [D-1:0] w_ent_val;

    logic [1:0]   w_state_nxt;
    logic [D-1:0] w_pc_nxt;
    logic         w_taken_nxt;
    logic         w_fault_nxt;

    // Table read sees storage before this edge's write, so a same-cycle write is not bypassed.
    assign w_ent_vld = r_vld[branch_idx];
    assign w_ent_rel = r_rel[branch_idx];
    assign w_ent_val = r_val[branch_idx];

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_taken_nxt = 1'b0;
        w_fault_nxt = r_fault;
        case (r_state)
            ST_RUN: begin
                if (halt) begin
                    w_state_nxt = ST_HOLD;
                end else if (branch_en) begin
                    if (!w_ent_vld) begin
                        w_fault_nxt = 1'b1;
                        w_state_nxt = ST_FAULT;
                    end else begin
                        // Relative offsets are two's complement, so a plain modulo add handles negatives.
                        w_pc_nxt    = w_ent_rel ? (r_pc + w_ent_val) : w_ent_val;
                        w_taken_nxt = 1'b1;
                    end
                end else begin
                    w_pc_nxt = r_pc + PC_ONE;
                end
            end
            ST_HOLD: begin
                if (!halt) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_FAULT: begin
                w_fault_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_pc    <= '0;
            r_taken <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_taken <= w_taken_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld <= '0;
            r_rel <= '0;
            for (int i = 0; i < N; i++) begin
                r_val[i] <= '0;
            end
        end else if (tbl_we) begin
            r_vld[tbl_waddr] <= 1'b1;
            r_rel[tbl_waddr] <= tbl_wrel;
            r_val[tbl_waddr] <= tbl_wdata;
        end
    end

    assign pc    = r_pc;
    assign taken = r_taken;
    assign fault = r_fault;

endmodule
